// File: rtl/debug_run_controller.sv
// Run/halt/single-step sequencer that gates the core's commit enable.
// Halt sources: EBREAK decode, a bank of PC breakpoints, and debounced board keys.
module debug_run_controller #(
  parameter int NUM_BP          = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int PC_W            = 32,
  localparam int IDX_W          = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
  input  logic             iCLK,
  input  logic             Reset_n,
  input  logic [3:0]       iKEY,
  input  logic             iEbreak,
  input  logic [PC_W-1:0]  iPC,
  input  logic             iBP_WE,
  input  logic [IDX_W-1:0] iBP_IDX,
  input  logic [PC_W-1:0]  iBP_ADDR,
  input  logic             iBP_VALID,
  output logic             oCPU_EN,
  output logic             oBreak,
  output logic [1:0]       oCause,
  output logic [31:0]      oInstrCnt
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_HALT   = 2'd1;
  localparam logic [1:0] ST_STEP   = 2'd2;
  localparam logic [1:0] ST_RESUME = 2'd3;

  localparam logic [1:0] CAUSE_NONE   = 2'd0;
  localparam logic [1:0] CAUSE_EBREAK = 2'd1;
  localparam logic [1:0] CAUSE_BP     = 2'd2;
  localparam logic [1:0] CAUSE_MANUAL = 2'd3;

  // key[3] and the word-offset bits of both addresses take no part in any decision
  logic unused_ok;
  assign unused_ok = ^{iKEY[3], iBP_ADDR[1:0], iPC[1:0]};

  // ---------------------------------------------------------------------------
  // Key path: synchronizer, debounce, falling-edge press pulse (keys 0..2)
  // ---------------------------------------------------------------------------
  logic [2:0] press;

  for (genvar k = 0; k < 3; k++) begin : g_key
    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             accept;

    // The synced level has differed from the stable level for DEBOUNCE_CYCLES cycles
    assign accept   = (sync2_q != stable_q) && (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));
    assign press[k] = accept & ~sync2_q;

    always_comb begin
      cnt_d = '0;
      if (!accept && (sync2_q != stable_q)) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge iCLK or negedge Reset_n) begin
      if (!Reset_n) begin
        sync1_q  <= 1'b1;
        sync2_q  <= 1'b1;
        stable_q <= 1'b1;
        cnt_q    <= '0;
      end else begin
        sync1_q <= iKEY[k];
        sync2_q <= sync1_q;
        cnt_q   <= cnt_d;
        if (accept) stable_q <= sync2_q;
      end
    end
  end

  logic halt_press;
  logic step_press;
  logic resume_press;

  assign halt_press   = press[0];
  assign step_press   = press[1];
  assign resume_press = press[2];

  // ---------------------------------------------------------------------------
  // Breakpoint bank
  // ---------------------------------------------------------------------------
  logic [NUM_BP-1:0] bp_valid_q;
  logic [PC_W-3:0]   bp_addr_q [NUM_BP];
  logic [NUM_BP-1:0] bp_match;
  logic              bp_hit;

  always_ff @(posedge iCLK or negedge Reset_n) begin
    if (!Reset_n) begin
      bp_valid_q <= '0;
      for (int i = 0; i < NUM_BP; i++) bp_addr_q[i] <= '0;
    end else if (iBP_WE) begin
      for (int i = 0; i < NUM_BP; i++) begin
        if (iBP_IDX == IDX_W'(i)) begin
          bp_valid_q[i] <= iBP_VALID;
          bp_addr_q[i]  <= iBP_ADDR[PC_W-1:2];
        end
      end
    end
  end

  always_comb begin
    bp_match = '0;
    for (int i = 0; i < NUM_BP; i++) begin
      bp_match[i] = bp_valid_q[i] && (bp_addr_q[i] == iPC[PC_W-1:2]);
    end
  end

  assign bp_hit = |bp_match;

  // ---------------------------------------------------------------------------
  // Run/halt FSM
  // ---------------------------------------------------------------------------
  logic [1:0]  state_q;
  logic [1:0]  state_d;
  logic [1:0]  cause_q;
  logic [1:0]  cause_d;
  logic        post_step_q;
  logic        cpu_en;
  logic [31:0] instr_cnt_q;

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    cpu_en  = 1'b0;
    case (state_q)
      ST_RUN: begin
        cpu_en = ~(iEbreak | bp_hit | halt_press);
        if (!cpu_en) begin
          state_d = ST_HALT;
          cause_d = iEbreak ? CAUSE_EBREAK : (bp_hit ? CAUSE_BP : CAUSE_MANUAL);
        end
      end
      ST_HALT: begin
        // After a step the new PC may itself be a stop reason; report that one
        if (post_step_q && (iEbreak || bp_hit)) begin
          cause_d = iEbreak ? CAUSE_EBREAK : CAUSE_BP;
        end
        if (step_press)        state_d = ST_STEP;
        else if (resume_press) state_d = ST_RESUME;
      end
      ST_STEP: begin
        cpu_en  = 1'b1;
        state_d = ST_HALT;
      end
      ST_RESUME: begin
        cpu_en  = 1'b1;
        state_d = ST_RUN;
        cause_d = CAUSE_NONE;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge iCLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= ST_RUN;
      cause_q     <= CAUSE_NONE;
      post_step_q <= 1'b0;
      instr_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cause_q     <= cause_d;
      post_step_q <= (state_q == ST_STEP);
      instr_cnt_q <= instr_cnt_q + 32'(cpu_en);
    end
  end

  assign oCPU_EN   = cpu_en;
  assign oBreak    = (state_q == ST_HALT);
  assign oCause    = cause_q;
  assign oInstrCnt = instr_cnt_q;

endmodule
